reg_file_8x8: RTL and testbench

REG_FILE_8X8 -- requirements
Module: reg_file_8x8

---
 rtl/reg_file_8x8.sv | 52 +++++
 tb/tb_reg_file_8x8.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_8x8.sv
// 8-entry register file with one write port and two combinational read ports.
// Optional write-to-read forwarding is selected by the BYPASS parameter.
module reg_file_8x8 #(
    parameter int DATA_W = 8,
    parameter bit BYPASS = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [2:0]        INADDRESS,
    input  logic              WRITE,
    input  logic [2:0]        OUT1ADDRESS,
    input  logic [2:0]        OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2
);

    logic [DATA_W-1:0] r_regs [8];
    logic [DATA_W-1:0] w_out1;
    logic [DATA_W-1:0] w_out2;

    // NOTE: the array is reset as a whole because every index must read 0 after reset,
    // which rules out a plain RAM macro here; non-blocking updates keep reads pre-edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WRITE) begin
            r_regs[INADDRESS] <= IN;
        end
    end

    // NOTE: each output gets its stored value first, so no path leaves it unassigned.
    always_comb begin
        w_out1 = r_regs[OUT1ADDRESS];
        w_out2 = r_regs[OUT2ADDRESS];
        if (BYPASS && WRITE && RESET) begin
            if (OUT1ADDRESS == INADDRESS) w_out1 = IN;
            if (OUT2ADDRESS == INADDRESS) w_out2 = IN;
        end
        // Forced low during reset so forwarded write data never leaks out.
        if (!RESET) begin
            w_out1 = '0;
            w_out2 = '0;
        end
    end

    assign OUT1 = w_out1;
    assign OUT2 = w_out2;

endmodule

// File: tb/tb_reg_file_8x8.sv
// Scoreboarded bench: a plain-array model predicts both read ports of a BYPASS=0
// and a BYPASS=1 instance that share the same stimulus.
module tb_reg_file_8x8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] out1_d0, out2_d0, out1_d1, out2_d1;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } sb_t;

    sb_t        sb[$];
    logic [7:0] mdl [8];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 CLK = ~CLK;

    reg_file_8x8 #(.DATA_W(8), .BYPASS(1'b0)) u_nobyp (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_d0), .OUT2(out2_d0)
    );

    reg_file_8x8 #(.DATA_W(8), .BYPASS(1'b1)) u_byp (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_d1), .OUT2(out2_d1)
    );

    function automatic logic [7:0] predict(bit byp, logic [2:0] a);
        if (!RESET) return 8'h00;
        if (byp && WRITE && a == INADDRESS) return IN;
        return mdl[a];
    endfunction

    // sel: 0 = nobyp OUT1, 1 = nobyp OUT2, 2 = byp OUT1, 3 = byp OUT2
    function automatic logic [7:0] observed(int sel);
        case (sel)
            0:       return out1_d0;
            1:       return out2_d0;
            2:       return out1_d1;
            default: return out2_d1;
        endcase
    endfunction

    task automatic push_reads(string name);
        for (int s = 0; s < 4; s++) begin
            sb.push_back('{name, s, predict(s >= 2, s[0] ? OUT2ADDRESS : OUT1ADDRESS)});
        end
    endtask

    task automatic do_write(logic [2:0] a, logic [7:0] d);
        @(negedge CLK);
        WRITE = 1'b1; INADDRESS = a; IN = d;
        @(posedge CLK);
        if (RESET) mdl[a] = d;
        #1;
        WRITE = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b0; WRITE = 1'b1; IN = 8'hA5; INADDRESS = 3'd0;
        OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        WRITE = 1'b0;
        RESET = 1'b1;
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(7 - a);
            push_reads("reset_zero");
            #1;
            while (sb.size() > 0) begin
                sb_t e = sb.pop_front();
                n_tests++;
                if (observed(e.sel) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s sel%0d addr%0d: got %h expected %h", e.name, e.sel, a, observed(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_write;
        do_write(3'd3, 8'h2A);
        do_write(3'd5, 8'h0E);
        OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5;
        push_reads("write_r3_r5");
        for (int a = 0; a < 8; a++) begin
            #1;
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'((a + 1) % 8);
            push_reads("write_others");
        end
        // Entries are sampled in order, so re-drive each address before its pop.
        for (int k = 0; k < 9; k++) begin
            if (k == 0) begin OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5; end
            else begin OUT1ADDRESS = 3'(k - 1); OUT2ADDRESS = 3'(k % 8); end
            #1;
            for (int s = 0; s < 4; s++) begin
                sb_t e = sb.pop_front();
                n_tests++;
                if (observed(e.sel) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s sel%0d step%0d: got %h expected %h", e.name, e.sel, k, observed(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_hold;
        @(negedge CLK);
        WRITE = 1'b0; IN = 8'hFF; INADDRESS = 3'd3; OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd2;
        repeat (3) begin
            @(posedge CLK);
            push_reads("hold_no_write");
            #1;
            while (sb.size() > 0) begin
                sb_t e = sb.pop_front();
                n_tests++;
                if (observed(e.sel) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, observed(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_forward;
        do_write(3'd2, 8'h07);
        @(negedge CLK);
        WRITE = 1'b1; IN = 8'h36; INADDRESS = 3'd2; OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd3;
        push_reads("forward_pre_edge");
        #1;
        while (sb.size() > 0) begin
            sb_t e = sb.pop_front();
            n_tests++;
            if (observed(e.sel) !== e.exp) begin
                n_fail++;
                $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, observed(e.sel), e.exp);
            end
        end
        @(posedge CLK);
        mdl[2] = 8'h36;
        #1;
        push_reads("forward_post_edge");
        #1;
        WRITE = 1'b0;
        while (sb.size() > 0) begin
            sb_t e = sb.pop_front();
            n_tests++;
            if (observed(e.sel) !== e.exp) begin
                n_fail++;
                $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, observed(e.sel), e.exp);
            end
        end
    endtask

    task automatic test_boundaries;
        // IN changes mid-cycle: only the value at the edge lands in R4.
        @(negedge CLK);
        WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h11;
        #2 IN = 8'h22;
        @(posedge CLK);
        mdl[4] = 8'h22;
        #1;
        WRITE = 1'b0;
        do_write(3'd0, 8'h80);
        do_write(3'd7, 8'hFF);
        do_write(3'd6, 8'hC3);
        OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd6;
        push_reads("same_addr_r6");
        #1;
        while (sb.size() > 0) begin
            sb_t e = sb.pop_front();
            n_tests++;
            if (observed(e.sel) !== e.exp) begin
                n_fail++;
                $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, observed(e.sel), e.exp);
            end
        end
        foreach (mdl[a]) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(a);
            push_reads("boundary_regs");
            #1;
            while (sb.size() > 0) begin
                sb_t e = sb.pop_front();
                n_tests++;
                if (observed(e.sel) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s sel%0d addr%0d: got %h expected %h", e.name, e.sel, a, observed(e.sel), e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_write(3'd1, 8'h55);
        @(negedge CLK);
        WRITE = 1'b1; IN = 8'h99; INADDRESS = 3'd1; OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd1;
        #2 RESET = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        push_reads("reset_mid_immediate");
        #1;
        while (sb.size() > 0) begin
            sb_t e = sb.pop_front();
            n_tests++;
            if (observed(e.sel) !== e.exp) begin
                n_fail++;
                $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, observed(e.sel), e.exp);
            end
        end
        @(posedge CLK);
        #1;
        push_reads("reset_held_edge");
        #1;
        while (sb.size() > 0) begin
            sb_t e = sb.pop_front();
            n_tests++;
            if (observed(e.sel) !== e.exp) begin
                n_fail++;
                $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, observed(e.sel), e.exp);
            end
        end
        @(negedge CLK);
        WRITE = 1'b0;
        RESET = 1'b1;
        push_reads("reset_write_discarded");
        #1;
        while (sb.size() > 0) begin
            sb_t e = sb.pop_front();
            n_tests++;
            if (observed(e.sel) !== e.exp) begin
                n_fail++;
                $display("FAIL %s sel%0d: got %h expected %h", e.name, e.sel, observed(e.sel), e.exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            WRITE       = ($urandom_range(3) != 0);
            INADDRESS   = 3'($urandom_range(7));
            IN          = 8'($urandom);
            OUT1ADDRESS = (c % 4 == 0) ? INADDRESS : 3'($urandom_range(7));
            OUT2ADDRESS = (c % 3 == 0) ? INADDRESS : 3'($urandom_range(7));
            push_reads("b2b_pre_edge");
            #1;
            while (sb.size() > 0) begin
                sb_t e = sb.pop_front();
                n_tests++;
                if (observed(e.sel) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s sel%0d cycle%0d: got %h expected %h", e.name, e.sel, c, observed(e.sel), e.exp);
                end
            end
            @(posedge CLK);
            if (WRITE) mdl[INADDRESS] = IN;
        end
        #1;
        WRITE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_write;
        test_hold;
        test_forward;
        test_boundaries;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
